// File: rtl/load_store_unit_pkg.sv
// ============================================================================
// Module      : load_store_unit_pkg
// Description : Shared types for the MEM-stage load/store unit. Holds the
//               request op encoding, the fault codes and the FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package load_store_unit_pkg;

    // Request op encoding as presented on req_op
    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LH  = 3'd1,
        OP_LW  = 3'd2,
        OP_LBU = 3'd3,
        OP_LHU = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } op_e;

    // Fault codes reported on fault_code
    localparam logic [1:0] FLT_NONE     = 2'd0;
    localparam logic [1:0] FLT_MISALIGN = 2'd1;
    localparam logic [1:0] FLT_RANGE    = 2'd2;

    // Access sequencer states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LD_WAIT  = 2'd1,
        ST_RMW_WAIT = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/load_store_unit_lane_align.sv
// ============================================================================
// Module      : lsu_lane_align
// Description : Combinational byte-lane logic. Extracts and sign/zero-extends
//               the addressed byte/halfword of a memory word for loads, and
//               merges store data into the addressed lane for stores.
// Ports       : op_i       - request op (op_e encoding)
//               byte_sel_i - req_addr[1:0]
//               rdata_i    - word read from memory
//               wdata_i    - right-justified store data
//               ld_data_o  - extended load result
//               st_data_o  - word to write back
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [1:0]  byte_sel_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] ld_data_o,
    output logic [31:0] st_data_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Little-endian lanes: byte k at [8k+7:8k], halfword h=addr[1] at [16h+15:16h]
    assign w_byte = rdata_i[{byte_sel_i, 3'b000} +: 8];
    assign w_half = rdata_i[{byte_sel_i[1], 4'b0000} +: 16];

    always_comb begin
        ld_data_o = rdata_i;
        case (op_e'(op_i))
            OP_LB:   ld_data_o = {{24{w_byte[7]}}, w_byte};
            OP_LH:   ld_data_o = {{16{w_half[15]}}, w_half};
            OP_LBU:  ld_data_o = {24'd0, w_byte};
            OP_LHU:  ld_data_o = {16'd0, w_half};
            default: ld_data_o = rdata_i;
        endcase
    end

    always_comb begin
        st_data_o = wdata_i;
        case (op_e'(op_i))
            OP_SB: begin
                st_data_o = rdata_i;
                st_data_o[{byte_sel_i, 3'b000} +: 8] = wdata_i[7:0];
            end
            OP_SH: begin
                st_data_o = rdata_i;
                st_data_o[{byte_sel_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            end
            default: st_data_o = wdata_i;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module      : load_store_unit
// Description : MEM-stage initiator for a word-wide data memory. Turns byte-
//               addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word
//               accesses (sub-word stores by read-modify-write), stalls the
//               pipeline while an access is in flight and reports misaligned
//               or out-of-range requests without touching memory.
// Ports       : clk, rst (async, active-high)
//               req_valid/req_op/req_addr/req_wdata - MEM-stage request
//               stall                - freeze IF..MEM
//               ld_valid/ld_data     - load result pulse
//               fault/fault_code     - dropped-request pulse
//               MemRead/MemWrite/Addr/Wdata/Rdata - data memory interface
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter logic [31:0] MEM_BASE_WORD = 32'h0010_0000,
    parameter int unsigned MEM_WORDS     = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] Addr,
    output logic [31:0] Wdata,
    input  logic [31:0] Rdata
);

    state_e      state_q, state_d;
    logic [31:0] w_word;
    logic        w_misalign;
    logic        w_in_range;
    logic [31:0] w_ld_data;
    logic [31:0] w_st_data;

    assign w_word = {2'b00, req_addr[31:2]};

    // Unsigned offset from the base also rejects indices below the window
    assign w_in_range = ((w_word - MEM_BASE_WORD) < 32'(MEM_WORDS));

    always_comb begin
        w_misalign = 1'b0;
        case (op_e'(req_op))
            OP_LW, OP_SW:         w_misalign = (req_addr[1:0] != 2'b00);
            OP_LH, OP_LHU, OP_SH: w_misalign = req_addr[0];
            default:              w_misalign = 1'b0;
        endcase
    end

    lsu_lane_align u_lane_align (
        .op_i       (req_op),
        .byte_sel_i (req_addr[1:0]),
        .rdata_i    (Rdata),
        .wdata_i    (req_wdata),
        .ld_data_o  (w_ld_data),
        .st_data_o  (w_st_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs are decoded from state and the held request. In IDLE the
    // request is qualified with ~rst so nothing leaks out while in reset.
    always_comb begin
        state_d    = state_q;
        stall      = 1'b0;
        ld_valid   = 1'b0;
        ld_data    = 32'd0;
        fault      = 1'b0;
        fault_code = FLT_NONE;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        Addr       = 32'd0;
        Wdata      = 32'd0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && !rst) begin
                    Addr = w_word;
                    if (w_misalign) begin
                        fault      = 1'b1;
                        fault_code = FLT_MISALIGN;
                    end else if (!w_in_range) begin
                        fault      = 1'b1;
                        fault_code = FLT_RANGE;
                    end else begin
                        case (op_e'(req_op))
                            OP_SW: begin
                                MemWrite = 1'b1;
                                Wdata    = req_wdata;
                            end
                            OP_SB, OP_SH: begin
                                MemRead = 1'b1;
                                stall   = 1'b1;
                                state_d = ST_RMW_WAIT;
                            end
                            default: begin
                                MemRead = 1'b1;
                                stall   = 1'b1;
                                state_d = ST_LD_WAIT;
                            end
                        endcase
                    end
                end
            end
            ST_LD_WAIT: begin
                Addr     = w_word;
                ld_valid = 1'b1;
                ld_data  = w_ld_data;
                state_d  = ST_IDLE;
            end
            ST_RMW_WAIT: begin
                Addr     = w_word;
                MemWrite = 1'b1;
                Wdata    = w_st_data;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit with a 5-word data
//               memory model and a scoreboard of expected completion events.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;

    localparam logic [31:0] C_BASE = 32'h0010_0000;
    localparam int          C_WORDS = 5;

    localparam int K_LD  = 0;
    localparam int K_FLT = 1;
    localparam int K_WR  = 2;

    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        stall, ld_valid, fault, MemRead, MemWrite;
    logic [31:0] ld_data, Addr, Wdata;
    logic [1:0]  fault_code;
    logic [31:0] Rdata = 32'd0;

    logic [31:0] mem [0:C_WORDS-1] = '{32'h11223344, 32'h8899AABB, 32'hCAFEF00D,
                                       32'h01020304, 32'hA5A55A5A};

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .fault      (fault),
        .fault_code (fault_code),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Addr       (Addr),
        .Wdata      (Wdata),
        .Rdata      (Rdata)
    );

    // Data memory: samples strobes at the rising edge, read data next cycle
    always @(posedge clk) begin
        logic [31:0] idx;
        idx = Addr - C_BASE;
        if (MemRead) Rdata <= (idx < C_WORDS) ? mem[idx] : 32'hDEADDEAD;
        if (MemWrite && idx < C_WORDS) mem[idx] <= Wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per completion event
    always @(negedge clk) begin
        chk("strobe_excl", {31'd0, MemRead & MemWrite}, 32'd0);
        if (ld_valid || fault || MemWrite) begin
            if (q.size() == 0) begin
                chk("unexpected_event", {29'd0, ld_valid, fault, MemWrite}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                case (e.kind)
                    K_LD: begin
                        chk("ld_valid", {31'd0, ld_valid}, 32'd1);
                        chk("ld_data", ld_data, e.d);
                    end
                    K_FLT: begin
                        chk("fault", {31'd0, fault}, 32'd1);
                        chk("fault_code", {30'd0, fault_code}, e.d);
                        chk("fault_quiet", {29'd0, MemRead, MemWrite, stall}, 32'd0);
                    end
                    default: begin
                        chk("wr_strobe", {31'd0, MemWrite}, 32'd1);
                        chk("wr_addr", Addr, e.a);
                        chk("wr_data", Wdata, e.d);
                    end
                endcase
            end
        end else begin
            chk("ld_data_idle", ld_data, 32'd0);
            chk("fault_code_idle", {30'd0, fault_code}, 32'd0);
        end
    end

    task automatic push(input int kind, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.kind = kind;
        e.a    = a;
        e.d    = d;
        q.push_back(e);
    endtask

    // Present a request and hold it until the DUT drops stall
    task automatic issue(input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input int exp_stall);
        int n;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        n = 0;
        forever begin
            @(negedge clk);
            if (!stall) break;
            n++;
            if (n > 10) break;
        end
        chk("stall_cycles", n, exp_stall);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with a live request: everything must stay quiet
        req_valid = 1'b1;
        req_op    = 3'd2;
        req_addr  = 32'h0040_0004;
        @(negedge clk);
        chk("rst_ctrl", {25'd0, MemRead, MemWrite, stall, ld_valid, fault, fault_code}, 32'd0);
        chk("rst_addr", Addr, 32'd0);
        chk("rst_wdata", Wdata, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = 1'b0;
        @(posedge clk);
        #1;

        // Sub-word loads on word 1 = 8899AABB
        push(K_LD, 0, 32'hFFFF_FFAA); issue(3'd0, 32'h0040_0005, 0, 1);
        push(K_LD, 0, 32'h0000_00AA); issue(3'd3, 32'h0040_0005, 0, 1);
        push(K_LD, 0, 32'hFFFF_8899); issue(3'd1, 32'h0040_0006, 0, 1);
        push(K_LD, 0, 32'h0000_8899); issue(3'd4, 32'h0040_0006, 0, 1);

        // SB read-modify-write then read back
        push(K_WR, 32'h0010_0001, 32'h8812_AABB); issue(3'd5, 32'h0040_0006, 32'h12, 1);
        push(K_LD, 0, 32'h8812_AABB); issue(3'd2, 32'h0040_0004, 0, 1);

        // Faults: misalign wins over range
        push(K_FLT, 0, 32'd1); issue(3'd2, 32'h0040_0002, 0, 0);
        push(K_FLT, 0, 32'd2); issue(3'd7, 32'h0040_0014, 32'hFFFF_FFFF, 0);
        push(K_FLT, 0, 32'd2); issue(3'd2, 32'h003F_FFFC, 0, 0);
        push(K_FLT, 0, 32'd1); issue(3'd6, 32'h0040_0001, 0, 0);
        push(K_FLT, 0, 32'd1); issue(3'd2, 32'h0000_0001, 0, 0);
        idle();

        // Back-to-back full-word stores
        push(K_WR, 32'h0010_0000, 32'h0BAD_F00D); issue(3'd7, 32'h0040_0000, 32'h0BAD_F00D, 0);
        push(K_WR, 32'h0010_0001, 32'h1357_7531); issue(3'd7, 32'h0040_0004, 32'h1357_7531, 0);
        idle();
        chk("mem0_sw", mem[0], 32'h0BAD_F00D);
        chk("mem1_sw", mem[1], 32'h1357_7531);
        chk("mem4_untouched", mem[4], 32'hA5A5_5A5A);

        push(K_LD, 0, 32'h0000_7531); issue(3'd1, 32'h0040_0004, 0, 1);
        push(K_LD, 0, 32'h0000_0013); issue(3'd0, 32'h0040_0007, 0, 1);
        push(K_LD, 0, 32'h0000_005A); issue(3'd0, 32'h0040_0010, 0, 1);
        push(K_LD, 0, 32'hFFFF_FFA5); issue(3'd0, 32'h0040_0013, 0, 1);

        // SH upper half, then read back both ways
        push(K_WR, 32'h0010_0002, 32'hBEEF_F00D); issue(3'd6, 32'h0040_000A, 32'h0000_BEEF, 1);
        push(K_LD, 0, 32'h0000_BEEF); issue(3'd4, 32'h0040_000A, 0, 1);
        push(K_LD, 0, 32'hFFFF_BEEF); issue(3'd1, 32'h0040_000A, 0, 1);
        idle();

        // Reset in RMW_WAIT of SH 0x00400008: no write may happen
        req_valid = 1'b1;
        req_op    = 3'd6;
        req_addr  = 32'h0040_0008;
        req_wdata = 32'h0000_5555;
        @(negedge clk);
        chk("rmw_rd", {30'd0, MemRead, stall}, 32'd3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rmw_rst_ctrl", {25'd0, MemRead, MemWrite, stall, ld_valid, fault, fault_code}, 32'd0);
        chk("rmw_rst_addr", Addr, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rmw_rst_mem", mem[2], 32'hBEEF_F00D);
        push(K_LD, 0, 32'hBEEF_F00D); issue(3'd2, 32'h0040_0008, 0, 1);

        // SB uses only the low byte of store data
        push(K_WR, 32'h0010_0004, 32'h77A5_5A5A); issue(3'd5, 32'h0040_0013, 32'hFFFF_FF77, 1);
        push(K_LD, 0, 32'h77A5_5A5A); issue(3'd2, 32'h0040_0010, 0, 1);
        idle();

        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        chk("queue_drain", q.size(), 32'd0);
        chk("mem3_untouched", mem[3], 32'h0102_0304);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
MEM-stage initiator for the pipelined MIPS CPU's word-wide data memory. It drives the MemRead/MemWrite/Addr/Wdata interface and consumes Rdata. It converts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses; sub-word stores use read-modify-write. It stalls the pipeline while an access is in flight and flags misaligned or out-of-range accesses without touching memory.

Parameters:
MEM_BASE_WORD, 32'h0010_0000, first valid word index of data memory
MEM_WORDS, 5, number of implemented words (valid indices BASE..BASE+MEM_WORDS-1)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  MEM-stage request present; held stable by pipeline while stall=1
req_op  in  3  0 LB, 1 LH, 2 LW, 3 LBU, 4 LHU, 5 SB, 6 SH, 7 SW
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified for SB/SH
stall  out  1  freeze IF..MEM; high while request accepted but not done
ld_valid  out  1  one-cycle pulse, ld_data valid
ld_data  out  32  extended load result; 0 when ld_valid=0
fault  out  1  one-cycle pulse, request dropped
fault_code  out  2  1 misaligned, 2 out of range; 0 when fault=0
MemRead  out  1  memory read strobe; sampled by memory at rising edge
MemWrite  out  1  memory write strobe; sampled by memory at rising edge
Addr  out  32  word index = {2'b00, req_addr[31:2]}
Wdata  out  32  word write data
Rdata  in  32  memory read data; valid the cycle after MemRead is sampled

Behaviour:
- Clock is clk; reset is rst, asynchronous and active-high. While rst=1 and after its release, state=IDLE and all outputs are 0.
- Byte lanes are little-endian: byte k (addr[1:0]=k) occupies bits [8k+7:8k]. Halfword h=addr[1] occupies bits [16h+15:16h].
- Checks are combinational from req_addr in IDLE, with priority misalign > range:
  - misaligned: LW/SW with addr[1:0]≠0, or LH/LHU/SH with addr[0]=1
  - out of range: word index outside [MEM_WORDS window]
  - On fault: fault=1, fault_code is set, no strobe is driven, stall=0, state stays IDLE. Completes in 0 extra cycles.
- FSM states: IDLE, LD_WAIT, RMW_WAIT.
  - IDLE, load: MemRead=1 and stall=1; next state LD_WAIT.
  - LD_WAIT: ld_data = extract(Rdata), with sign-extension for LB/LH and zero-extension for LBU/LHU. ld_valid=1, stall=0; next state IDLE. Load latency is 1 stall cycle.
  - IDLE, SW: MemWrite=1, Wdata=req_wdata, stall=0. Single cycle, no stall.
  - IDLE, SB/SH: MemRead=1, stall=1; next state RMW_WAIT.
  - RMW_WAIT: MemWrite=1, Wdata = Rdata with the target lane replaced by req_wdata[7:0] or [15:0]. stall=0; next state IDLE.
- Addr is driven from req_addr in every state. MemRead and MemWrite are never both 1.
- MemRead/MemWrite/Wdata are 0 whenever no access is driven.
- req_valid=0 in IDLE: all outputs 0. req_valid is ignored in LD_WAIT/RMW_WAIT; the request is already held by stall.
- Back-to-back requests: the cycle after a completing cycle is IDLE, so a new request is accepted with no bubble.
- Reset mid-operation (LD_WAIT/RMW_WAIT): access is aborted with no ld_valid and no MemWrite. An interrupted RMW leaves memory unchanged.

Decomposition:
- Shared package: op encodings (OP_LB..OP_SW), fault codes (FLT_NONE/FLT_MISALIGN/FLT_RANGE), FSM state enum.
- Sub-module: lsu_lane_align (combinational). It performs load extract/extend and store lane merge from op, addr[1:0], Rdata and req_wdata. The FSM stays in load_store_unit.

Test Plan:
- Memory word 0x00100001 = 0x8899AABB; LB 0x00400005 -> MemRead one cycle, next cycle ld_valid, ld_data=0xFFFFFFAA. LBU same address -> 0x000000AA.
- LH 0x00400006 on same word -> ld_data=0xFFFF8899. LHU -> 0x00008899. stall high exactly one cycle each.
- SB 0x00400006 wdata 0x12 -> cycle0 MemRead, cycle1 MemWrite Wdata=0x8812AABB; subsequent LW 0x00400004 returns 0x8812AABB.
- LW 0x00400002 -> fault=1, fault_code=1, no strobes, stall=0. SW 0x00400014 (word 0x00100005) -> fault_code=2, memory unchanged.
- SW 0x00400000 then SW 0x00400004 on consecutive cycles -> MemWrite both cycles, stall never asserted, both words written.
- Assert rst during RMW_WAIT of SH 0x00400008 -> MemWrite never asserted, word unchanged, all outputs 0, next request served from IDLE.
